// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port shared by imem_loader and its neighbours.
// slave is the loader side; master is the byte source / memory side.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 10
) ();
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Assembles a little-endian byte stream into 32-bit words and writes them to instruction memory from word 0.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [ADDR_WIDTH:0] i_word_count,
    imem_loader_if.slave        bus,
    output logic                o_busy,
    output logic                o_cpu_hold,
    output logic                o_done,
    output logic                o_error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_CHECK = 2'd2, S_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_DONE = 2'd3} state_t;
`endif

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   r_word_idx;
    logic [ADDR_WIDTH:0]   w_word_idx_inc;
    logic [1:0]            r_byte_idx;
    logic [23:0]           r_buf;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic                  w_byte_ready;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_accept;
    logic                  w_last_byte;

    assign w_word_idx_inc = r_word_idx + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign w_accept       = bus.byte_valid && w_byte_ready;
    assign w_last_byte    = w_accept && (r_state == S_LOAD) && (r_byte_idx == 2'd3);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = (i_word_count == {(ADDR_WIDTH+1){1'b0}}) ? S_DONE : S_LOAD;
                end else begin
                    w_next = S_IDLE;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_LOAD: begin
                if (w_last_byte && (w_word_idx_inc == r_count)) begin
                    w_next = S_CHECK;
                end else begin
                    w_next = S_LOAD;
                end
            end
            S_CHECK: begin
                if (w_accept) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_CHECK;
                end
            end
`else
            // The final write occupies one LOAD cycle with byte_ready low before DONE.
            S_LOAD: begin
                if (r_word_idx == r_count) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_LOAD;
                end
            end
`endif
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_byte_ready = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
            end
            S_LOAD: begin
                w_busy       = 1'b1;
                w_byte_ready = (r_word_idx != r_count);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                w_busy       = 1'b1;
                w_byte_ready = 1'b1;
            end
`endif
            S_DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_error;

    // Checksum accumulator and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum  <= 8'h00;
            r_error <= 1'b0;
        end else if ((r_state == S_IDLE) && i_start) begin
            r_csum  <= 8'h00;
            r_error <= 1'b0;
        end else if (w_accept && (r_state == S_LOAD)) begin
            r_csum  <= r_csum ^ bus.byte_data;
        end else if (w_accept && (r_state == S_CHECK)) begin
            r_error <= (bus.byte_data != r_csum);
        end
    end

    assign o_error = r_error;
`else
    assign o_error = 1'b0;
`endif

    // Word assembly and memory write register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= {(ADDR_WIDTH+1){1'b0}};
            r_word_idx  <= {(ADDR_WIDTH+1){1'b0}};
            r_byte_idx  <= 2'd0;
            r_buf       <= 24'h000000;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_WIDTH{1'b0}};
            r_mem_wdata <= 32'h00000000;
        end else begin
            r_mem_we <= 1'b0;
            if ((r_state == S_IDLE) && i_start) begin
                r_count    <= i_word_count;
                r_word_idx <= {(ADDR_WIDTH+1){1'b0}};
                r_byte_idx <= 2'd0;
                r_buf      <= 24'h000000;
            end else if (w_accept && (r_state == S_LOAD)) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                case (r_byte_idx)
                    2'd0: r_buf[7:0]   <= bus.byte_data;
                    2'd1: r_buf[15:8]  <= bus.byte_data;
                    2'd2: r_buf[23:16] <= bus.byte_data;
                    2'd3: begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_word_idx[ADDR_WIDTH-1:0];
                        r_mem_wdata <= {bus.byte_data, r_buf};
                        r_word_idx  <= w_word_idx_inc;
                    end
                    default: r_buf <= r_buf;
                endcase
            end
        end
    end

    assign bus.byte_ready = w_byte_ready;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign o_busy         = w_busy;
    assign o_cpu_hold     = w_busy;
    assign o_done         = w_done;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams checked against a word-list reference model.
module tb_imem_loader;
    localparam int AW = 10;
    typedef logic [7:0] byte_q_t [$];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [AW:0]   i_word_count = '0;
    logic          o_busy, o_cpu_hold, o_done, o_error;

    imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_word_count (i_word_count),
        .bus          (bus),
        .o_busy       (o_busy),
        .o_cpu_hold   (o_cpu_hold),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int ready_bad = 0;
    int hold_bad = 0;
    int last_xfer_cyc = 0;
    int g_wbase, g_dbase, g_rbase, g_hbase;
    logic [7:0]    last_csum;
    logic [AW-1:0] mon_addr [$];
    logic [31:0]   mon_data [$];
    int            mon_cyc  [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe writes, done pulses and handshake hygiene on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_we) begin
                mon_addr.push_back(bus.mem_addr);
                mon_data.push_back(bus.mem_wdata);
                mon_cyc.push_back(cyc);
            end
            if (o_done) done_cnt <= done_cnt + 1;
            if (bus.byte_ready && !o_busy) ready_bad <= ready_bad + 1;
            if (o_cpu_hold !== o_busy) hold_bad <= hold_bad + 1;
        end
    end

    function automatic logic [7:0] xor_of(input byte_q_t bq);
        logic [7:0] x = 8'h00;
        foreach (bq[i]) x ^= bq[i];
        return x;
    endfunction

    function automatic logic [31:0] model_word(input byte_q_t bq, input int w);
        return {bq[4*w+3], bq[4*w+2], bq[4*w+1], bq[4*w]};
    endfunction

    function automatic int exp_lat();
`ifdef IMEM_LOADER_CHECKSUM_EN
        return 1;
`else
        return 2;
`endif
    endfunction

    task automatic do_start(input int cnt);
        i_start      = 1'b1;
        i_word_count = cnt[AW:0];
        @(posedge clk); #1;
        i_start      = 1'b0;
        i_word_count = AW'($urandom);
    endtask

    task automatic put_byte(input logic [7:0] b, input int gap);
        bit seen = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            seen = bus.byte_ready;
            @(posedge clk); #1;
        end
        if (!seen) begin
            errors++;
            $display("FAIL put_byte_timeout: byte_ready=0, required 1");
        end
        last_xfer_cyc  = cyc;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'($urandom);
    endtask

    task automatic wait_done(output int lat);
        bit seen = 1'b0;
        lat = 0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            seen = o_done;
        end
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: done=0 after %0d cycles, required 1", lat);
        end
    endtask

    task automatic run_load(input int cnt, input byte_q_t bq, input logic [7:0] csum,
                            input int gap_lo, input int gap_hi, input bit noise,
                            output int lat, output int data_cyc);
        g_wbase   = mon_addr.size();
        g_dbase   = done_cnt;
        g_rbase   = ready_bad;
        g_hbase   = hold_bad;
        last_csum = csum;
        do_start(cnt);
        data_cyc = cyc;
        foreach (bq[i]) begin
            put_byte(bq[i], int'($urandom_range(gap_hi, gap_lo)));
            data_cyc = last_xfer_cyc;
            if (noise && i == 2) begin
                i_start = 1'b1; i_word_count = 11'd7;
                @(posedge clk); #1;
                i_start = 1'b0;
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (cnt != 0) put_byte(last_csum, 0);
`endif
        wait_done(lat);
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_start = 1'($urandom); i_word_count = AW'($urandom);
        bus.byte_valid = 1'($urandom); bus.byte_data = 8'($urandom);
        #3;
        checks++;
        if ({o_busy, o_cpu_hold, o_done, o_error, bus.byte_ready, bus.mem_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 000000",
                     {o_busy, o_cpu_hold, o_done, o_error, bus.byte_ready, bus.mem_we});
        end
        checks++;
        if (bus.mem_addr !== '0 || bus.mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h wdata=%h, required 0/0", bus.mem_addr, bus.mem_wdata);
        end
        i_start = 1'b0; bus.byte_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_two_words(input string name, input int lat, input int dc);
        checks++;
        if (mon_addr.size() - g_wbase !== 2) begin
            errors++;
            $display("FAIL %s_wcount: got %0d writes, required 2", name, mon_addr.size() - g_wbase);
        end else begin
            checks++;
            if (mon_addr[g_wbase] !== 10'd0 || mon_data[g_wbase] !== 32'h00000013) begin
                errors++;
                $display("FAIL %s_w0: got %h@%h, required 00000013@000", name, mon_data[g_wbase], mon_addr[g_wbase]);
            end
            checks++;
            if (mon_addr[g_wbase+1] !== 10'd1 || mon_data[g_wbase+1] !== 32'h00100093) begin
                errors++;
                $display("FAIL %s_w1: got %h@%h, required 00100093@001", name, mon_data[g_wbase+1], mon_addr[g_wbase+1]);
            end
            checks++;
            if (mon_cyc[g_wbase+1] !== dc) begin
                errors++;
                $display("FAIL %s_wtime: write cycle %0d, required %0d", name, mon_cyc[g_wbase+1], dc);
            end
        end
        checks++;
        if (lat !== exp_lat()) begin
            errors++;
            $display("FAIL %s_done_lat: got %0d, required %0d", name, lat, exp_lat());
        end
        checks++;
        if (done_cnt - g_dbase !== 1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: pulses=%0d busy=%b, required 1/0", name, done_cnt - g_dbase, o_busy);
        end
    endtask

    task automatic test_basic();
        byte_q_t bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        int lat, dc;
        run_load(2, bq, xor_of(bq), 0, 0, 1'b0, lat, dc);
        check_two_words("basic", lat, dc);
    endtask

    task automatic test_gaps_and_start();
        byte_q_t bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        int lat, dc;
        run_load(2, bq, xor_of(bq), 1, 1, 1'b1, lat, dc);
        check_two_words("gaps", lat, dc);
    endtask

    task automatic test_zero_count();
        byte_q_t bq = {};
        int lat, dc;
        run_load(0, bq, 8'h00, 0, 0, 1'b0, lat, dc);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL zero_done_lat: got %0d, required 1", lat);
        end
        checks++;
        if (mon_addr.size() - g_wbase !== 0 || ready_bad - g_rbase !== 0) begin
            errors++;
            $display("FAIL zero_quiet: writes=%0d ready_cycles=%0d, required 0/0",
                     mon_addr.size() - g_wbase, ready_bad - g_rbase);
        end
    endtask

    task automatic test_reset_midload();
        byte_q_t bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
        byte_q_t b2 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        int lat, dc;
        g_wbase = mon_addr.size();
        do_start(4);
        foreach (bq[i]) put_byte(bq[i], 0);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL midload_busy: got %b, required 1", o_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_cpu_hold, o_done, bus.byte_ready, bus.mem_we} !== 5'b0 || bus.mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL midload_async_reset: flags=%b wdata=%h, required 00000/0",
                     {o_busy, o_cpu_hold, o_done, bus.byte_ready, bus.mem_we}, bus.mem_wdata);
        end
        checks++;
        if (mon_addr.size() - g_wbase !== 1 || mon_data[g_wbase] !== 32'h00000013 || mon_addr[g_wbase] !== 10'd0) begin
            errors++;
            $display("FAIL midload_first_writes: count=%0d, required one write 00000013@000", mon_addr.size() - g_wbase);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_load(1, b2, xor_of(b2), 0, 0, 1'b0, lat, dc);
        checks++;
        if (mon_addr.size() - g_wbase !== 1 || mon_data[g_wbase] !== 32'hDEADBEEF || mon_addr[g_wbase] !== 10'd0) begin
            errors++;
            $display("FAIL midload_reload: count=%0d, required one write deadbeef@000", mon_addr.size() - g_wbase);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int cnt = int'($urandom_range(6, 1));
            byte_q_t bq = {};
            logic [7:0] cs;
            bit exp_err;
            int lat, dc, bad;
            for (int k = 0; k < 4 * cnt; k++) bq.push_back(8'($urandom));
            cs = $urandom_range(1, 0) ? xor_of(bq) : 8'($urandom);
`ifdef IMEM_LOADER_CHECKSUM_EN
            exp_err = (cs != xor_of(bq));
`else
            exp_err = 1'b0;
`endif
            run_load(cnt, bq, cs, 0, 3, 1'($urandom), lat, dc);
            bad = 0;
            if (mon_addr.size() - g_wbase == cnt) begin
                for (int w = 0; w < cnt; w++)
                    if (mon_addr[g_wbase+w] !== AW'(w) || mon_data[g_wbase+w] !== model_word(bq, w)) bad++;
            end else begin
                bad = 1000;
            end
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL random_writes it=%0d: writes=%0d bad=%0d, required %0d writes, 0 bad",
                         it, mon_addr.size() - g_wbase, bad, cnt);
            end
            checks++;
            if (o_error !== exp_err || lat !== exp_lat()) begin
                errors++;
                $display("FAIL random_status it=%0d: error=%b lat=%0d, required %b/%0d", it, o_error, lat, exp_err, exp_lat());
            end
            checks++;
            if (hold_bad - g_hbase !== 0 || ready_bad - g_rbase !== 0) begin
                errors++;
                $display("FAIL random_hold it=%0d: hold_mismatch=%0d idle_ready=%0d, required 0/0",
                         it, hold_bad - g_hbase, ready_bad - g_rbase);
            end
        end
    endtask

    task automatic test_full_depth();
        byte_q_t bq = {};
        int lat, dc, bad;
        for (int k = 0; k < 4 * 1024; k++) bq.push_back(8'($urandom));
        run_load(1024, bq, xor_of(bq), 0, 0, 1'b0, lat, dc);
        bad = 0;
        if (mon_addr.size() - g_wbase == 1024) begin
            for (int w = 0; w < 1024; w++)
                if (mon_addr[g_wbase+w] !== AW'(w) || mon_data[g_wbase+w] !== model_word(bq, w)) bad++;
        end else begin
            bad = 100000;
        end
        checks++;
        if (bad !== 0 || lat !== exp_lat()) begin
            errors++;
            $display("FAIL full_depth: writes=%0d bad=%0d lat=%0d, required 1024/0/%0d",
                     mon_addr.size() - g_wbase, bad, lat, exp_lat());
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        byte_q_t bq = '{8'h01, 8'h02, 8'h04, 8'h08};
        int lat, dc;
        run_load(1, bq, 8'h0F, 0, 0, 1'b0, lat, dc);
        checks++;
        if (o_error !== 1'b0) begin
            errors++;
            $display("FAIL csum_good: error=%b, required 0", o_error);
        end
        run_load(1, bq, 8'h00, 0, 0, 1'b0, lat, dc);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (o_error !== 1'b1) begin
            errors++;
            $display("FAIL csum_bad_hold: error=%b, required 1", o_error);
        end
        do_start(1);
        checks++;
        if (o_error !== 1'b0) begin
            errors++;
            $display("FAIL csum_clear_on_start: error=%b, required 0", o_error);
        end
        foreach (bq[i]) put_byte(bq[i], 0);
        put_byte(8'h0F, 0);
        wait_done(lat);
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        test_reset();
        test_basic();
        test_gaps_and_start();
        test_zero_count();
        test_reset_midload();
        test_random();
        test_full_depth();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side companion to the instruction memory: accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and issues one write per word into the instruction memory's word-addressed array, starting at word 0. The loader holds the core stalled while a load is in progress and signals completion with a one-cycle pulse. It sits between the boot/debug byte source (UART receiver, testbench driver) and the instruction memory write port.

## Interface

- ADDR_WIDTH, 10, word-address width; must match the instruction memory (depth 2^ADDR_WIDTH words)
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a load; sampled only in IDLE
- word_count  in  ADDR_WIDTH+1  number of words to load (0..2^ADDR_WIDTH); latched when start is accepted
- byte_valid  in  1  byte_data valid
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle; a byte transfers when byte_valid && byte_ready
- mem_we  out  1  instruction memory write enable, one cycle per word
- mem_addr  out  ADDR_WIDTH  word address of the write
- mem_wdata  out  32  assembled instruction word
- busy  out  1  load in progress
- cpu_hold  out  1  stall request to core; equals busy
- done  out  1  one-cycle completion pulse
- error  out  1  checksum mismatch flag (see Configuration)

## Operation

- States: IDLE, LOAD, CHECK (only with checksum), DONE.
- IDLE: byte_ready=0, busy=0. start=1 → latch word_count, clear word index, byte index, checksum accumulator and error; go LOAD if word_count≠0, else DONE.
- LOAD: busy=1, byte_ready=1. Each accepted byte goes to lane byte_index (first byte → bits 7:0, fourth → 31:24); byte_index increments mod 4.
- On the fourth byte: next cycle mem_we=1, mem_addr=word index, mem_wdata=assembled word; word index increments. If that was word word_count−1 → CHECK (checksum build) or DONE.
- CHECK: byte_ready=1; one accepted byte is compared with the XOR of all 4·word_count data bytes; mismatch sets error; → DONE.
- DONE: done=1, busy=0, byte_ready=0; → IDLE next cycle.
- start while not in IDLE is ignored. Bytes presented in IDLE/DONE are not accepted.
- Word index is ADDR_WIDTH+1 bits; word_count=2^ADDR_WIDTH writes addresses 0..2^ADDR_WIDTH−1 with no wrap and no extra write.
- Reset mid-load: all state cleared immediately, partial word discarded, no further mem_we.

## Timing

- Reset values: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, cpu_hold=0, done=0, error=0; state IDLE.
- start accepted at cycle T → busy=1, byte_ready=1 at T+1 (word_count≠0) or done=1 at T+1 (word_count=0).
- Fourth byte accepted at T → mem_we=1 at T+1 for exactly one cycle; mem_addr/mem_wdata stable while mem_we=1.
- Last word's fourth byte at T: without checksum, write at T+1, done=1 at T+2; with checksum, write at T+1 and CHECK entered at T+1.
- Checksum byte accepted at T → done=1 and error valid at T+1; error holds until next accepted start.
- Back-to-back bytes: one byte per cycle sustained; byte_valid gaps only delay, never duplicate or drop.

## Configuration

- IMEM_LOADER_CHECKSUM_EN defined: CHECK state present; one trailing checksum byte (XOR of all data bytes) is consumed after the last word; error reports mismatch. word_count=0 skips CHECK.
- Not defined: no CHECK state, no checksum byte consumed, error tied to 0.

## Test plan

- Reset asserted mid-cycle with random inputs → all outputs 0 asynchronously, state IDLE.
- start, word_count=2, bytes 13 00 00 00 93 00 10 00 back-to-back → writes addr0=0x00000013, addr1=0x00100093, each mem_we one cycle, done one cycle, busy low after.
- Same load with byte_valid toggling every other cycle plus start pulsed during LOAD → identical two writes, no extra writes, second start ignored.
- start with word_count=0 → no mem_we, done=1 at T+1, byte_ready never asserted.
- rst_n low after 6 bytes of a 4-word load, then new 1-word load of EF BE AD DE → only writes addr0=0x00000013 (first load) and addr0=0xDEADBEEF; partial word never written.
- With IMEM_LOADER_CHECKSUM_EN: 1 word 01 02 04 08 + checksum 0F → error=0; repeat with checksum 00 → error=1, held until next start.
